// File: rtl/riscv_pkg.sv
// Shared core types: machine width, instruction alignment and the fetch queue entry.
package riscv_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_ALIGN = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_prims.sv
// Datapath primitives for the fetch stage: 2:1 mux, modulo adder, enabled register.
module mux2x1 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             sel_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);
  assign y_o = sel_i ? b_i : a_i;
endmodule

module adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o
);
  // Carry out is dropped on purpose: PC arithmetic wraps modulo 2^WIDTH.
  assign sum_o = a_i + b_i;
endmodule

module register #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] val_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q <= RESET_VAL;
    end else if (en_i) begin
      val_q <= d_i;
    end
  end

  assign q_o = val_q;
endmodule

// File: rtl/fetch_queue.sv
// Circular FIFO of {pc,instr} fetch entries; flush wins over enqueue/dequeue in the same cycle.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   enq_i,
  input  fetch_entry_t           enq_data_i,
  input  logic                   deq_i,
  output logic                   vld_o,
  output fetch_entry_t           head_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (deq_i) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({enq_i, deq_i})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (enq_i && !flush_i) begin
        mem_q[wr_ptr_q] <= enq_data_i;
      end
    end
  end

  assign vld_o   = (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, 1-cycle imem requests, fetch queue to decode, redirect flush.
// Request -> out_valid is 2 cycles; issue is throttled so queued + in-flight never exceeds QUEUE_DEPTH.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int unsigned      WIDTH       = XLEN,
  parameter logic [WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned      QUEUE_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req_valid,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc,
  output logic [WIDTH-1:0] out_instr
);
  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] next_pc;
  logic [WIDTH-1:0] redirect_aligned;
  logic             inflight_q, inflight_d;
  logic [WIDTH-1:0] inflight_addr_q, inflight_addr_d;
  logic [CW-1:0]    count;
  logic [CW:0]      occupancy;
  logic             head_vld;
  logic             enq;
  logic             deq;
  fetch_entry_t     enq_entry;
  fetch_entry_t     head_entry;

  assign redirect_aligned = redirect_pc & ~WIDTH'(INSTR_ALIGN - 1);

  mux2x1 #(.WIDTH(WIDTH)) u_redirect_mux (
    .sel_i (redirect_valid),
    .a_i   (pc_q),
    .b_i   (redirect_aligned),
    .y_o   (imem_addr)
  );

  adder #(.WIDTH(WIDTH)) u_next_pc (
    .a_i   (imem_addr),
    .b_i   (WIDTH'(INSTR_ALIGN)),
    .sum_o (next_pc)
  );

  register #(.WIDTH(WIDTH), .RESET_VAL(RESET_PC)) u_pc_reg (
    .clk  (clk),
    .rst  (reset),
    .en_i (imem_req_valid),
    .d_i  (next_pc),
    .q_o  (pc_q)
  );

  // A redirect empties the queue and kills the in-flight response, so the target always issues.
  assign out_valid = head_vld && !redirect_valid;
  assign deq       = out_valid && out_ready;
  assign occupancy = redirect_valid ? '0
                   : ({1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(deq));
  assign imem_req_valid = !reset && (occupancy < (CW+1)'(QUEUE_DEPTH));

  assign enq             = inflight_q && !redirect_valid;
  assign enq_entry.pc    = inflight_addr_q;
  assign enq_entry.instr = imem_rdata;

  always_comb begin
    inflight_d      = imem_req_valid;
    inflight_addr_d = imem_req_valid ? imem_addr : inflight_addr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
    end else begin
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
    end
  end

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk        (clk),
    .rst        (reset),
    .flush_i    (redirect_valid),
    .enq_i      (enq),
    .enq_data_i (enq_entry),
    .deq_i      (deq),
    .vld_o      (head_vld),
    .head_o     (head_entry),
    .count_o    (count)
  );

  assign out_pc    = head_entry.pc;
  assign out_instr = head_entry.instr;
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench: queue-based reference model of the fetch stream plus literal stream checks.
module tb_fetch_stage;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: PCs waiting in the queue, and the request awaiting its response.
  logic [31:0] m_pc;
  logic [31:0] m_fifo[$];
  bit          m_pend;
  logic [31:0] m_pend_addr;
  logic [31:0] mem_next;

  logic [31:0] acc_log[$];
  logic [31:0] exp_log[$];
  logic        last_ovld, last_req;
  logic [31:0] last_pc, last_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    m_fifo.delete();
    m_pend = 1'b0;
    m_pend_addr = 32'h0;
    acc_log.delete();
  endtask

  // Entered and left at posedge+1; holds reset for two edges.
  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    out_ready = 1'b0;
    imem_rdata = $urandom;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    model_reset();
    mem_next = $urandom;
  endtask

  task automatic step(input bit rv, input logic [31:0] rpc, input bit rdy);
    bit          e_ovld, e_deq, e_req;
    logic [31:0] e_addr;
    int          occ;
    reset = 1'b0;
    redirect_valid = rv;
    redirect_pc = rpc;
    out_ready = rdy;
    imem_rdata = mem_next;
    #4;
    e_ovld = (m_fifo.size() != 0) && !rv;
    e_deq  = e_ovld && rdy;
    if (rv) begin
      e_addr = {rpc[31:2], 2'b00};
      e_req  = 1'b1;
    end else begin
      e_addr = m_pc;
      occ    = m_fifo.size() + int'(m_pend) - int'(e_deq);
      e_req  = (occ < 2);
    end
    chk("out_valid", 32'(out_valid), 32'(e_ovld));
    chk("req_valid", 32'(imem_req_valid), 32'(e_req));
    chk("imem_addr", imem_addr, e_addr);
    if (e_ovld) begin
      chk("out_pc", out_pc, m_fifo[0]);
      chk("out_instr", out_instr, m_fifo[0] ^ KEY);
    end
    last_ovld = out_valid;
    last_req  = imem_req_valid;
    last_pc   = out_pc;
    last_addr = imem_addr;
    if (out_valid && out_ready) acc_log.push_back(out_pc);
    mem_next = imem_req_valid ? (imem_addr ^ KEY) : $urandom;
    if (rv) begin
      m_fifo.delete();
    end else begin
      if (e_deq) void'(m_fifo.pop_front());
      if (m_pend) m_fifo.push_back(m_pend_addr);
    end
    m_pend = e_req;
    m_pend_addr = e_addr;
    if (e_req) m_pc = e_addr + 32'd4;
    @(posedge clk); #1;
  endtask

  task automatic chk_log(input string name);
    chk({name, "_len"}, 32'(acc_log.size()), 32'(exp_log.size()));
    for (int i = 0; i < exp_log.size() && i < acc_log.size(); i++) begin
      chk(name, acc_log[i], exp_log[i]);
    end
  endtask

  initial begin
    reset = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    out_ready = 1'b0;
    imem_rdata = 32'h0;
    @(posedge clk); #1;

    // Streaming from reset
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);
    exp_log = '{32'h0, 32'h4, 32'h8, 32'hC};
    chk_log("stream");

    // Stall then release
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b0);
    chk("stall_valid", 32'(last_ovld), 32'd1);
    chk("stall_pc", last_pc, 32'h0);
    chk("stall_req", 32'(last_req), 32'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);
    exp_log = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
    chk_log("release");

    // Redirect with a full queue
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h100, 1'b1);
    chk("redir_forced_invalid", 32'(last_ovld), 32'd0);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);
    exp_log = '{32'h100, 32'h104, 32'h108, 32'h10C};
    chk_log("redirect");

    // Unaligned target and back-to-back redirects
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h203, 1'b1);
    chk("align_addr", last_addr, 32'h200);
    step(1'b1, 32'h300, 1'b1);
    step(1'b1, 32'h400, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);
    exp_log = '{32'h0, 32'h400, 32'h404, 32'h408, 32'h40C};
    chk_log("b2b_redirect");

    // PC wrap
    do_reset();
    step(1'b1, 32'hFFFF_FFF8, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);
    exp_log = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
    chk_log("wrap");

    // Asynchronous reset mid-stream
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0);
    chk("pre_reset_valid", 32'(last_ovld), 32'd1);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);
    exp_log = '{32'h0, 32'h4};
    chk_log("restart");

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 7) == 0), $urandom, ($urandom_range(0, 2) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
